// File: rtl/video_pkg.sv
// ============================================================================
// Module      : video_pkg
// Description : Shared definitions for the OV7725 capture path: sequencer
//               state encoding, sensor geometry defaults and power-up timing
//               defaults.
// Contents    : state_t            - sequencer state enum
//               C_ROW_NUM ...      - geometry and timing defaults
//               max3()             - largest of three counts
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package video_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_PWRUP   = 3'd1,
        ST_SRST    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CONFIG  = 3'd4,
        ST_IDLE    = 3'd5,
        ST_ARMED   = 3'd6,
        ST_CAPTURE = 3'd7
    } state_t;

    // OV7725 QVGA geometry, RGB565
    localparam int C_ROW_NUM       = 240;
    localparam int C_PIXEL_NUM     = 320;
    localparam int C_BYTES_PER_PIX = 2;
    localparam int C_ADDR_WIDTH    = 18;

    // Power-up sequencing in clk cycles
    localparam int C_PWUP_CYCLES   = 1024;
    localparam int C_RST_CYCLES    = 256;
    localparam int C_SETTLE_CYCLES = 4096;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_capture_ctrl_edge_det.sv
// ============================================================================
// Module      : edge_det
// Description : Registered edge detector for an already-synchronized level.
//               Holds the previous sample; edges are that sample compared
//               with the current level.
// Ports       : clk, rstn - clock, asynchronous active-low reset
//               sig       - input level
//               rise/fall - single-cycle edge indications
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic r_sig_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_sig_d <= 1'b0;
        else       r_sig_d <= sig;
    end

    assign rise = sig & ~r_sig_d;
    assign fall = ~sig & r_sig_d;

endmodule

`default_nettype wire

// File: rtl/video_capture_ctrl.sv
// ============================================================================
// Module      : video_capture_ctrl
// Description : OV7725 video-path sequencer. Powers the sensor up (pwdn, then
//               vreset pulse, then settle), requests SCCB configuration, then
//               converts vsync/href/pix_vld into frame-buffer byte writes and
//               reports frame completion and geometry errors.
// Ports       : clk, rstn          - clock, asynchronous active-low reset
//               start, continuous  - control from the recognition core
//               sccb_done          - configuration complete pulse
//               vsync, href,pix_vld- synchronized video strobes
//               pwdn, vreset       - sensor power-down / reset
//               cfg_start          - configuration request pulse
//               wr_en, wr_addr     - frame-buffer byte write
//               busy, done, err_len- status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_capture_ctrl
    import video_pkg::*;
#(
    parameter int ROW_NUM       = C_ROW_NUM,
    parameter int PIXEL_NUM     = C_PIXEL_NUM,
    parameter int BYTES_PER_PIX = C_BYTES_PER_PIX,
    parameter int ADDR_WIDTH    = C_ADDR_WIDTH,
    parameter int PWUP_CYCLES   = C_PWUP_CYCLES,
    parameter int RST_CYCLES    = C_RST_CYCLES,
    parameter int SETTLE_CYCLES = C_SETTLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  sccb_done,
    input  logic                  vsync,
    input  logic                  href,
    input  logic                  pix_vld,
    output logic                  pwdn,
    output logic                  vreset,
    output logic                  cfg_start,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err_len
);

    localparam int LINE_BYTES = PIXEL_NUM * BYTES_PER_PIX;
    // Byte counter can reach LINE_BYTES+1 so an over-long line stays
    // distinguishable from an exact one.
    localparam int BW = $clog2(LINE_BYTES + 2);
    localparam int LW = $clog2(ROW_NUM + 1);
    localparam int SW = $clog2(max3(PWUP_CYCLES, RST_CYCLES, SETTLE_CYCLES) + 1);

    localparam logic [BW-1:0] C_LINE_BYTES  = BW'(LINE_BYTES);
    localparam logic [LW-1:0] C_LAST_LINE   = LW'(ROW_NUM - 1);
    localparam logic [SW-1:0] C_PWUP_LAST   = SW'(PWUP_CYCLES - 1);
    localparam logic [SW-1:0] C_RST_LAST    = SW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] C_SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t                r_state,     w_state;
    logic [SW-1:0]         r_seq_cnt,   w_seq_cnt;
    logic [LW-1:0]         r_line_cnt,  w_line_cnt;
    logic [BW-1:0]         r_byte_cnt,  w_byte_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_next, w_addr_next;
    logic [ADDR_WIDTH-1:0] r_wr_addr,   w_wr_addr;
    logic r_pwdn, w_pwdn, r_vreset, w_vreset, r_cfg_start, w_cfg_start;
    logic r_wr_en, w_wr_en, r_busy, w_busy, r_done, w_done, r_err, w_err;

    logic w_vsync_rise, w_vsync_fall, w_href_rise, w_href_fall;
    logic w_frame_end;

    edge_det u_vsync_edge (
        .clk  (clk),
        .rstn (rstn),
        .sig  (vsync),
        .rise (w_vsync_rise),
        .fall (w_vsync_fall)
    );

    edge_det u_href_edge (
        .clk  (clk),
        .rstn (rstn),
        .sig  (href),
        .rise (w_href_rise),
        .fall (w_href_fall)
    );

    logic w_unused;
    assign w_unused = &{1'b0, w_vsync_fall, w_href_rise};

    assign w_frame_end = w_href_fall && (r_line_cnt == C_LAST_LINE);

    always_comb begin
        w_state     = r_state;
        w_seq_cnt   = r_seq_cnt;
        w_line_cnt  = r_line_cnt;
        w_byte_cnt  = r_byte_cnt;
        w_addr_next = r_addr_next;
        w_wr_addr   = r_wr_addr;
        w_pwdn      = r_pwdn;
        w_vreset    = r_vreset;
        w_err       = r_err;
        w_cfg_start = 1'b0;
        w_wr_en     = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            ST_OFF: begin
                if (start) begin
                    w_state   = ST_PWRUP;
                    w_pwdn    = 1'b0;
                    w_vreset  = 1'b1;
                    w_seq_cnt = '0;
                    w_err     = 1'b0;
                end
            end
            ST_PWRUP: begin
                if (r_seq_cnt == C_PWUP_LAST) begin
                    w_state   = ST_SRST;
                    w_vreset  = 1'b0;
                    w_seq_cnt = '0;
                end else begin
                    w_seq_cnt = r_seq_cnt + SW'(1);
                end
            end
            ST_SRST: begin
                if (r_seq_cnt == C_RST_LAST) begin
                    w_state   = ST_SETTLE;
                    w_vreset  = 1'b1;
                    w_seq_cnt = '0;
                end else begin
                    w_seq_cnt = r_seq_cnt + SW'(1);
                end
            end
            ST_SETTLE: begin
                if (r_seq_cnt == C_SETTLE_LAST) begin
                    w_state     = ST_CONFIG;
                    w_cfg_start = 1'b1;
                    w_seq_cnt   = '0;
                end else begin
                    w_seq_cnt = r_seq_cnt + SW'(1);
                end
            end
            ST_CONFIG: begin
                // A done pulse coincident with our own request is stale.
                if (sccb_done && !r_cfg_start) w_state = ST_ARMED;
            end
            ST_IDLE: begin
                if (start) begin
                    w_state = ST_ARMED;
                    w_err   = 1'b0;
                end
            end
            ST_ARMED: begin
                if (w_vsync_rise) begin
                    w_state     = ST_CAPTURE;
                    w_line_cnt  = '0;
                    w_byte_cnt  = '0;
                    w_addr_next = '0;
                    w_wr_addr   = '0;
                end
            end
            ST_CAPTURE: begin
                if (pix_vld && href) begin
                    if (r_byte_cnt < C_LINE_BYTES) begin
                        w_wr_en     = 1'b1;
                        w_wr_addr   = r_addr_next;
                        w_addr_next = r_addr_next + ADDR_WIDTH'(1);
                        w_byte_cnt  = r_byte_cnt + BW'(1);
                    end else if (r_byte_cnt == C_LINE_BYTES) begin
                        w_byte_cnt = r_byte_cnt + BW'(1);
                    end
                end
                if (w_href_fall) begin
                    if (r_byte_cnt != C_LINE_BYTES) w_err = 1'b1;
                    w_byte_cnt = '0;
                    w_line_cnt = r_line_cnt + LW'(1);
                    if (w_frame_end) begin
                        w_done  = 1'b1;
                        w_state = continuous ? ST_ARMED : ST_IDLE;
                    end
                end
                // Line accounting above happens first; a vsync edge that does
                // not coincide with the final line is a short frame.
                if (w_vsync_rise && !w_frame_end) begin
                    w_err       = 1'b1;
                    w_wr_en     = 1'b0;
                    w_line_cnt  = '0;
                    w_byte_cnt  = '0;
                    w_addr_next = '0;
                    w_wr_addr   = '0;
                end
            end
            default: w_state = ST_OFF;
        endcase

        w_busy = !((w_state == ST_OFF) || (w_state == ST_IDLE));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_OFF;
            r_seq_cnt   <= '0;
            r_line_cnt  <= '0;
            r_byte_cnt  <= '0;
            r_addr_next <= '0;
            r_wr_addr   <= '0;
            r_pwdn      <= 1'b1;
            r_vreset    <= 1'b0;
            r_cfg_start <= 1'b0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_seq_cnt   <= w_seq_cnt;
            r_line_cnt  <= w_line_cnt;
            r_byte_cnt  <= w_byte_cnt;
            r_addr_next <= w_addr_next;
            r_wr_addr   <= w_wr_addr;
            r_pwdn      <= w_pwdn;
            r_vreset    <= w_vreset;
            r_cfg_start <= w_cfg_start;
            r_wr_en     <= w_wr_en;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    assign pwdn      = r_pwdn;
    assign vreset    = r_vreset;
    assign cfg_start = r_cfg_start;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_len   = r_err;

endmodule

`default_nettype wire

// File: doc/video_capture_ctrl.md
# video_capture_ctrl

Sequencer for the OV7725 camera video path. It powers up the sensor by driving `pwdn` and `vreset` in order, then requests register configuration from the SCCB master. Once configured, it arms on a frame boundary and turns synchronized vsync/href/pixel strobes into frame-buffer write enables and addresses. It also reports completion and frame-geometry errors to the image-recognition core.

## Interface
Parameters:
- `ROW_NUM`, 240: lines per frame.
- `PIXEL_NUM`, 320: pixels per line.
- `BYTES_PER_PIX`, 2: bytes per pixel (RGB565).
- `ADDR_WIDTH`, 18: frame-buffer byte address width. Must satisfy 2^ADDR_WIDTH ≥ ROW_NUM·PIXEL_NUM·BYTES_PER_PIX.
- `PWUP_CYCLES`, 1024: clk cycles from `pwdn` deassert to `vreset` assert.
- `RST_CYCLES`, 256: clk cycles `vreset` is held low.
- `SETTLE_CYCLES`, 4096: clk cycles after `vreset` release before configuration starts.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rstn` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse; begins power-up, or re-arms when in IDLE.
- `continuous` in 1: 1 = re-arm automatically after each frame. Sampled at the end of each frame.
- `sccb_done` in 1: one-cycle pulse from the SCCB master when configuration is complete.
- `vsync` in 1: frame sync, active high, already synchronized to `clk`.
- `href` in 1: line valid, already synchronized to `clk`.
- `pix_vld` in 1: one-cycle strobe per received byte, from the video sampler.
- `pwdn` out 1: sensor power-down, active high.
- `vreset` out 1: sensor reset, active low.
- `cfg_start` out 1: one-cycle pulse to the SCCB master.
- `wr_en` out 1: frame-buffer byte write.
- `wr_addr` out ADDR_WIDTH: frame-buffer byte address.
- `busy` out 1: high in any state other than OFF and IDLE.
- `done` out 1: one-cycle pulse when a frame completes.
- `err_len` out 1: sticky line-length or frame-length error.

## Operation
- States: OFF, PWRUP, SRST, SETTLE, CONFIG, IDLE, ARMED, CAPTURE.
- OFF: `pwdn`=1, `vreset`=0. On `start`: go to PWRUP and drop `pwdn`.
- PWRUP: count PWUP_CYCLES, then go to SRST.
- SRST: `vreset`=0 for RST_CYCLES, then go to SETTLE with `vreset`=1.
- SETTLE: count SETTLE_CYCLES, then pulse `cfg_start` for one cycle and enter CONFIG.
- CONFIG: wait for `sccb_done`, then enter ARMED. There is no timeout.
- ARMED: wait for a vsync rising edge (`vsync` & ~`vsync_d`). On the edge: clear the line/byte counters and `wr_addr`, then enter CAPTURE.
- CAPTURE:
  - `wr_en` = `pix_vld` & `href`. `wr_addr` increments after each write.
  - `pix_vld` with `href` low is ignored.
  - At an href falling edge:
    - If the byte count ≠ PIXEL_NUM·BYTES_PER_PIX, set `err_len`.
    - Increment the line count and clear the byte count.
  - When the line count reaches ROW_NUM: pulse `done`, then enter ARMED if `continuous`=1, else IDLE.
- Short frame: a vsync rising edge in CAPTURE before ROW_NUM lines sets `err_len`, emits no `done`, and restarts CAPTURE with cleared counters.
- Long line: writes with byte count ≥ PIXEL_NUM·BYTES_PER_PIX are suppressed (`wr_en`=0), so the buffer is never overrun. `err_len` is set at the href falling edge.
- IDLE: on `start`, go to ARMED. `start` in any other state except OFF is ignored.
- `err_len` clears only on the `start` pulse that leaves IDLE or OFF.

## Timing
- Reset values: state=OFF, `pwdn`=1, `vreset`=0, `cfg_start`=0, `wr_en`=0, `wr_addr`=0, `busy`=0, `done`=0, `err_len`=0.
- All outputs are registered; latency is one cycle from the causing input.
  - `wr_en`/`wr_addr` appear the cycle after `pix_vld`.
  - The address presented with a write is the pre-increment value (first write of a frame is address 0).
- `done` is asserted on the cycle after the href falling edge that completes the last line.
- When re-armed (`continuous`=1 or IDLE→ARMED), the next frame begins only on a fresh vsync rising edge.
- Simultaneous events:
  - An href falling edge and a vsync rising edge on the same cycle: the line is counted first, then the vsync check is applied.
  - `sccb_done` on the same cycle as `cfg_start` is ignored.
- Asserting `rstn` mid-capture returns the block to OFF and re-powers the sensor.

## Structure
- A shared package `video_pkg` holds:
  - the state enum and its encoding;
  - the OV7725 geometry defaults (ROW_NUM, PIXEL_NUM, BYTES_PER_PIX);
  - the timing cycle-count defaults.
- One sub-module, `edge_det`: registered rising/falling edge detector, instantiated for `vsync` and `href`.
- The sequencing counter is shared across PWRUP, SRST and SETTLE (width sized to the largest count). Line and byte counters are separate.

## Test plan
- **Power-up sequence.** Reset, then `start`.
  - `pwdn` falls 1 cycle after `start`.
  - `vreset` goes low for exactly 256 cycles, starting 1024 cycles later.
  - `cfg_start` pulses 4096 cycles after `vreset` rises.
- **Nominal frame.** `sccb_done`, then vsync pulse, then 240 lines of 640 `pix_vld`.
  - 153600 writes at addresses 0..153599.
  - One `done` pulse, `err_len`=0, state IDLE.
- **Continuous mode.** `continuous`=1, three frames.
  - Three `done` pulses.
  - `wr_addr` restarts at 0 after each vsync edge.
- **Short line.** One line of 638 bytes.
  - `err_len`=1 after that href falling edge.
  - Frame still completes after 240 lines.
- **Short frame and long line.**
  - vsync edge after 100 lines: `err_len`=1, no `done`, addresses restart at 0.
  - 700-byte line: only 640 `wr_en` for that line.
- **Mid-capture reset.** `rstn` low at line 50: all outputs return to reset values asynchronously, and the sequence restarts only on `start`.
